// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative, write-back, write-allocate data cache.
// The CPU side does zero-latency load hits. Misses evict an LRU (or invalid) way,
// write a dirty victim back over the line-wide bus, then fill from the bus.
// A bus-side snoop invalidate drops a matching line at any time.
module assoc_wb_cache #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int INDEX_LENGTH  = 6,
  parameter int OFFSET_LENGTH = 3,
  parameter int WAYS          = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  avalid,
  input  logic [ADDR_WIDTH-1:0]                 aaddr,
  input  logic                                  load,
  input  logic [DATA_WIDTH-1:0]                 data_from_cpu,
  output logic [DATA_WIDTH-1:0]                 data_to_cpu,
  output logic                                  hit,
  output logic                                  command_valid,
  output logic                                  command_store,
  output logic                                  command_rready,
  output logic [ADDR_WIDTH-1:0]                 command_addr,
  output logic [DATA_WIDTH*2**OFFSET_LENGTH-1:0] data_to_bus,
  input  logic [DATA_WIDTH*2**OFFSET_LENGTH-1:0] data_from_bus,
  input  logic                                  bus_valid,
  input  logic                                  bus_ready,
  input  logic                                  invalidate,
  input  logic [ADDR_WIDTH-1:0]                 invalidate_addr
);

  localparam int TAG_LENGTH = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH;
  localparam int WAY_BITS   = $clog2(WAYS);
  localparam int SETS       = 2**INDEX_LENGTH;
  localparam int WORDS      = 2**OFFSET_LENGTH;
  localparam int LINE_W     = DATA_WIDTH * WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  typedef logic [WAYS-1:0][WAY_BITS-1:0] age_vec_t;

  state_t state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]               valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0]               dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][WAY_BITS-1:0] age_q, age_d;
  logic [TAG_LENGTH-1:0]                   tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]                       line_q [SETS][WAYS];

  logic [WAY_BITS-1:0]   victim_way_q, victim_way_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_store_q, cmd_store_d;
  logic                  cmd_rready_q, cmd_rready_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [LINE_W-1:0]     wb_line_q, wb_line_d;

  logic [TAG_LENGTH-1:0]    req_tag, inv_tag;
  logic [INDEX_LENGTH-1:0]  req_idx, inv_idx;
  logic [OFFSET_LENGTH-1:0] req_off;
  logic [ADDR_WIDTH-1:0]    fill_addr;
  logic                     inv_off_unused;

  logic                  hit_any;
  logic [WAY_BITS-1:0]   hit_way;
  logic [WAY_BITS-1:0]   victim_way;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [LINE_W-1:0]     store_line, fill_line;
  logic                  mem_we;
  logic [WAY_BITS-1:0]   mem_way;
  logic [LINE_W-1:0]     mem_line;

  assign req_tag        = aaddr[ADDR_WIDTH-1 -: TAG_LENGTH];
  assign req_idx        = aaddr[OFFSET_LENGTH +: INDEX_LENGTH];
  assign req_off        = aaddr[OFFSET_LENGTH-1:0];
  assign inv_tag        = invalidate_addr[ADDR_WIDTH-1 -: TAG_LENGTH];
  assign inv_idx        = invalidate_addr[OFFSET_LENGTH +: INDEX_LENGTH];
  assign inv_off_unused = ^invalidate_addr[OFFSET_LENGTH-1:0];
  assign fill_addr      = {req_tag, req_idx, {OFFSET_LENGTH{1'b0}}};

  // Accessed way goes to age 0 and every younger way ages by one. Straight out of
  // reset all ages are 0, so while a set still holds duplicate ages a fill into an
  // invalid way is treated as replacing the oldest slot; this turns the ages into a
  // permutation by the time the set is full, after which the plain rule applies.
  function automatic age_vec_t lru_update(input age_vec_t ages,
                                          input logic [WAY_BITS-1:0] way,
                                          input logic was_valid);
    age_vec_t            nxt;
    logic [WAY_BITS-1:0] old;
    logic                distinct;
    distinct = 1'b1;
    for (int i = 0; i < WAYS; i++)
      for (int j = i + 1; j < WAYS; j++)
        if (ages[i] == ages[j]) distinct = 1'b0;
    old = (was_valid || distinct) ? ages[way] : WAY_BITS'(WAYS - 1);
    nxt = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_BITS'(w) == way) nxt[w] = '0;
      else if (ages[w] < old)  nxt[w] = ages[w] + 1'b1;
    end
    return nxt;
  endfunction

  // Tag compare across the ways of the requested set.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_BITS'(w);
      end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (age_q[req_idx][w] == WAY_BITS'(WAYS - 1)) victim_way = WAY_BITS'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[req_idx][w]) victim_way = WAY_BITS'(w);
  end

  // Word select for loads plus the merged lines for store hits and fills.
  always_comb begin
    hit_word   = '0;
    store_line = line_q[req_idx][hit_way];
    fill_line  = data_from_bus;
    for (int w = 0; w < WORDS; w++)
      if (req_off == OFFSET_LENGTH'(w)) begin
        hit_word = line_q[req_idx][hit_way][w*DATA_WIDTH +: DATA_WIDTH];
        store_line[w*DATA_WIDTH +: DATA_WIDTH] = data_from_cpu;
        if (!load) fill_line[w*DATA_WIDTH +: DATA_WIDTH] = data_from_cpu;
      end
  end

  assign hit            = (state_q == IDLE) && avalid && !invalidate && hit_any;
  assign data_to_cpu    = hit ? hit_word : '0;
  assign command_valid  = cmd_valid_q;
  assign command_store  = cmd_store_q;
  assign command_rready = cmd_rready_q;
  assign command_addr   = cmd_addr_q;
  assign data_to_bus    = wb_line_q;

  // Next-state, bus command and per-line status; snoop first so a same-cycle fill wins.
  always_comb begin
    state_d      = state_q;
    victim_way_d = victim_way_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_store_d  = cmd_store_q;
    cmd_rready_d = cmd_rready_q;
    cmd_addr_d   = cmd_addr_q;
    wb_line_d    = wb_line_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    age_d        = age_q;
    mem_we       = 1'b0;
    mem_way      = hit_way;
    mem_line     = store_line;

    for (int w = 0; w < WAYS; w++)
      if (invalidate && valid_q[inv_idx][w] && tag_q[inv_idx][w] == inv_tag) begin
        valid_d[inv_idx][w] = 1'b0;
        dirty_d[inv_idx][w] = 1'b0;
      end

    case (state_q)
      IDLE: begin
        if (avalid && !invalidate) begin
          if (hit_any) begin
            age_d[req_idx] = lru_update(age_q[req_idx], hit_way, 1'b1);
            if (!load) begin
              dirty_d[req_idx][hit_way] = 1'b1;
              mem_we                    = 1'b1;
            end
          end else begin
            victim_way_d = victim_way;
            cmd_valid_d  = 1'b1;
            if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
              state_d      = WRITEBACK;
              cmd_store_d  = 1'b1;
              cmd_rready_d = 1'b0;
              cmd_addr_d   = {tag_q[req_idx][victim_way], req_idx, {OFFSET_LENGTH{1'b0}}};
              wb_line_d    = line_q[req_idx][victim_way];
            end else begin
              state_d      = FILL;
              cmd_store_d  = 1'b0;
              cmd_rready_d = 1'b1;
              cmd_addr_d   = fill_addr;
              wb_line_d    = '0;
            end
          end
        end
      end
      WRITEBACK: begin
        if (bus_ready) begin
          state_d      = FILL;
          cmd_store_d  = 1'b0;
          cmd_rready_d = 1'b1;
          cmd_addr_d   = fill_addr;
          wb_line_d    = '0;
        end
      end
      FILL: begin
        if (bus_valid) begin
          state_d                        = IDLE;
          cmd_valid_d                    = 1'b0;
          cmd_rready_d                   = 1'b0;
          cmd_addr_d                     = '0;
          valid_d[req_idx][victim_way_q] = 1'b1;
          dirty_d[req_idx][victim_way_q] = !load;
          age_d[req_idx] = lru_update(age_q[req_idx], victim_way_q,
                                      valid_q[req_idx][victim_way_q]);
          mem_we   = 1'b1;
          mem_way  = victim_way_q;
          mem_line = fill_line;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, bus command registers and line status bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      victim_way_q <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_store_q  <= 1'b0;
      cmd_rready_q <= 1'b0;
      cmd_addr_q   <= '0;
      wb_line_q    <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      age_q        <= '0;
    end else begin
      state_q      <= state_d;
      victim_way_q <= victim_way_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_store_q  <= cmd_store_d;
      cmd_rready_q <= cmd_rready_d;
      cmd_addr_q   <= cmd_addr_d;
      wb_line_q    <= wb_line_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      age_q        <= age_d;
    end
  end

  // Tag and data arrays; write on store hit or fill, never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      line_q[req_idx][mem_way] <= mem_line;
      tag_q[req_idx][mem_way]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache (16-bit address, 4 sets, 4-word lines, 2 ways).
// A driver issues CPU requests and queues the expected hit data and bus commands;
// separate monitors pop and compare when the DUT presents hit or a new command.
module tb_assoc_wb_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         avalid;
  logic [15:0]  aaddr;
  logic         load;
  logic [63:0]  data_from_cpu;
  logic [63:0]  data_to_cpu;
  logic         hit;
  logic         command_valid;
  logic         command_store;
  logic         command_rready;
  logic [15:0]  command_addr;
  logic [255:0] data_to_bus;
  logic [255:0] data_from_bus;
  logic         bus_valid;
  logic         bus_ready;
  logic         invalidate;
  logic [15:0]  invalidate_addr;

  int checks = 0;
  int errors = 0;
  int wb_wait = 3;
  logic bus_hold = 1'b0;

  typedef struct {
    logic         st;
    logic [15:0]  addr;
    logic [255:0] line;
  } cmd_t;

  logic [63:0] exp_hit_q[$];
  cmd_t        exp_cmd_q[$];

  assoc_wb_cache #(
    .ADDR_WIDTH(16), .DATA_WIDTH(64), .INDEX_LENGTH(2), .OFFSET_LENGTH(2), .WAYS(2)
  ) dut (
    .clk(clk), .reset(reset), .avalid(avalid), .aaddr(aaddr), .load(load),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .hit(hit),
    .command_valid(command_valid), .command_store(command_store),
    .command_rready(command_rready), .command_addr(command_addr),
    .data_to_bus(data_to_bus), .data_from_bus(data_from_bus),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .invalidate(invalidate), .invalidate_addr(invalidate_addr)
  );

  always #5 clk = ~clk;

  // Memory image: line at tag t holds words 0x90+0x10*t+w (tag 1 -> 0xA0..0xA3).
  function automatic logic [255:0] line_for(input logic [15:0] a);
    logic [63:0]  base;
    logic [255:0] l;
    base = 64'h90 + 64'(a[15:4]) * 64'h10;
    for (int w = 0; w < 4; w++) l[w*64 +: 64] = base + 64'(w);
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic st, input logic [15:0] a, input logic [255:0] l);
    cmd_t c;
    c.st = st; c.addr = a; c.line = l;
    exp_cmd_q.push_back(c);
  endtask

  // Issue one request at posedge+1, wait for hit (bounded), check cycle latency.
  task automatic req(input logic [15:0] a, input logic ld, input logic [63:0] d,
                     input logic [63:0] exp_d, input int exp_lat);
    int n;
    n = 0;
    exp_hit_q.push_back(exp_d);
    aaddr = a; load = ld; data_from_cpu = d; avalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!hit && n < 60);
    if (!hit) begin
      checks++; errors++;
      $display("FAIL req_timeout: addr %h got no hit after %0d cycles", a, n);
      void'(exp_hit_q.pop_back());
    end else begin
      chk("latency", 256'(n), 256'(exp_lat));
    end
    @(posedge clk); #1;
    avalid = 1'b0;
  endtask

  // Hit monitor: every hit consumes one expected data word.
  initial forever begin
    @(negedge clk);
    if (hit) begin
      if (exp_hit_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL hit_unexpected: addr %h data %h, no hit expected", aaddr, data_to_cpu);
      end else begin
        chk("hit_data", data_to_cpu, exp_hit_q.pop_front());
      end
    end
  end

  // Command monitor: a new bus command consumes one expected command.
  initial begin
    logic        pv;
    logic        ps;
    logic [15:0] pa;
    cmd_t        e;
    pv = 1'b0; ps = 1'b0; pa = '0;
    forever begin
      @(negedge clk);
      if (command_valid && !(pv && ps == command_store && pa == command_addr)) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected: store=%0b addr=%h, none expected", command_store, command_addr);
        end else begin
          e = exp_cmd_q.pop_front();
          chk("cmd_store", 256'(command_store), 256'(e.st));
          chk("cmd_addr", 256'(command_addr), 256'(e.addr));
          chk("cmd_rready", 256'(command_rready), 256'(!e.st));
          if (e.st) chk("cmd_line", data_to_bus, e.line);
        end
      end
      pv = command_valid; ps = command_store; pa = command_addr;
    end
  end

  // Bus responder: fills answer one cycle after the read command appears;
  // write-backs are held off for wb_wait cycles.
  initial begin
    logic        pv;
    logic        ps;
    logic [15:0] pa;
    int          k;
    pv = 1'b0; ps = 1'b0; pa = '0; k = 0;
    bus_valid = 1'b0; bus_ready = 1'b0; data_from_bus = '0;
    forever begin
      @(negedge clk);
      if (command_valid) begin
        if (pv && ps == command_store && pa == command_addr) k++;
        else k = 1;
        bus_ready     = command_store && (k > wb_wait);
        bus_valid     = !command_store && !bus_hold;
        data_from_bus = line_for(command_addr);
      end else begin
        bus_ready = 1'b0; bus_valid = 1'b0; k = 0;
      end
      pv = command_valid; ps = command_store; pa = command_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] wl;
    reset = 1'b0; avalid = 1'b0; aaddr = '0; load = 1'b1; data_from_cpu = '0;
    invalidate = 1'b0; invalidate_addr = '0;
    #22;
    chk("rst_hit", 256'(hit), 256'(0));
    chk("rst_data_to_cpu", 256'(data_to_cpu), 256'(0));
    chk("rst_cmd_valid", 256'(command_valid), 256'(0));
    chk("rst_cmd_store", 256'(command_store), 256'(0));
    chk("rst_cmd_rready", 256'(command_rready), 256'(0));
    chk("rst_cmd_addr", 256'(command_addr), 256'(0));
    chk("rst_data_to_bus", data_to_bus, 256'(0));
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;

    // Cold miss, then store hit, load hit and a second-way fill.
    push_cmd(1'b0, 16'h0010, '0);
    req(16'h0010, 1'b1, 64'h0, 64'hA0, 3);
    req(16'h0011, 1'b0, 64'h55, 64'hA1, 1);
    req(16'h0011, 1'b1, 64'h0, 64'h55, 1);
    push_cmd(1'b0, 16'h0020, '0);
    req(16'h0020, 1'b1, 64'h0, 64'hB0, 3);

    // Dirty LRU victim in way0 is written back before the fill.
    wl = line_for(16'h0010);
    wl[64 +: 64] = 64'h55;
    push_cmd(1'b1, 16'h0010, wl);
    push_cmd(1'b0, 16'h0030, '0);
    req(16'h0030, 1'b1, 64'h0, 64'hC0, 7);
    req(16'h0030, 1'b1, 64'h0, 64'hC0, 1);

    // Clean victim (way1, tag 2) goes straight to fill; way0 survives.
    push_cmd(1'b0, 16'h0040, '0);
    req(16'h0040, 1'b1, 64'h0, 64'hD0, 3);
    req(16'h0030, 1'b1, 64'h0, 64'hC0, 1);

    // Snoop invalidate blocks the same-cycle request and drops the line.
    aaddr = 16'h0030; load = 1'b1; avalid = 1'b1;
    invalidate = 1'b1; invalidate_addr = 16'h0030;
    @(negedge clk);
    chk("inv_blocks_hit", 256'(hit), 256'(0));
    chk("inv_no_cmd", 256'(command_valid), 256'(0));
    @(posedge clk); #1;
    invalidate = 1'b0;
    push_cmd(1'b0, 16'h0030, '0);
    req(16'h0030, 1'b1, 64'h0, 64'hC0, 3);

    // Reset in the middle of a fill abandons it and invalidates everything.
    bus_hold = 1'b1;
    push_cmd(1'b0, 16'h0050, '0);
    aaddr = 16'h0050; load = 1'b1; avalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midfill_rst_cmd_valid", 256'(command_valid), 256'(0));
    chk("midfill_rst_cmd_rready", 256'(command_rready), 256'(0));
    chk("midfill_rst_cmd_addr", 256'(command_addr), 256'(0));
    chk("midfill_rst_hit", 256'(hit), 256'(0));
    avalid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; bus_hold = 1'b0;
    push_cmd(1'b0, 16'h0040, '0);
    req(16'h0040, 1'b1, 64'h0, 64'hD0, 3);

    // Store miss merges into the fill and leaves the line dirty.
    push_cmd(1'b0, 16'h0060, '0);
    req(16'h0061, 1'b0, 64'h77, 64'h77, 3);
    req(16'h0061, 1'b1, 64'h0, 64'h77, 1);
    req(16'h0062, 1'b1, 64'h0, 64'hF2, 1);
    push_cmd(1'b0, 16'h0070, '0);
    req(16'h0070, 1'b1, 64'h0, 64'h100, 3);
    wl = line_for(16'h0060);
    wl[64 +: 64] = 64'h77;
    push_cmd(1'b1, 16'h0060, wl);
    push_cmd(1'b0, 16'h0080, '0);
    req(16'h0080, 1'b1, 64'h0, 64'h110, 7);

    repeat (3) @(posedge clk);
    #1;
    chk("hit_queue_left", 256'(exp_hit_q.size()), 256'(0));
    chk("cmd_queue_left", 256'(exp_cmd_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
- N-way set-associative, write-back, write-allocate data cache between the CPU load/store port and the line-wide memory bus.
- Successor to the single-way cache, adding three things:
  - parametrised associativity, with LRU replacement and invalid-way preference;
  - per-line dirty bits, so only dirty victims are written back;
  - write-back before fill, with the victim's address correctly formed as {tag,index,0}.
- Bus-side snoop invalidation is retained.

Parameters:
ADDR_WIDTH, 64, byte/word address width
DATA_WIDTH, 64, CPU word width
INDEX_LENGTH, 6, set index bits (2**INDEX_LENGTH sets)
OFFSET_LENGTH, 3, word-in-line bits (line = DATA_WIDTH*2**OFFSET_LENGTH bits)
WAYS, 2, associativity, power of 2, >=2
(derived) TAG_LENGTH = ADDR_WIDTH-INDEX_LENGTH-OFFSET_LENGTH; WAY_BITS = $clog2(WAYS)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
avalid  in  1  CPU request valid; aaddr/load/data_from_cpu held stable until hit
aaddr  in  ADDR_WIDTH  {tag,index,offset}; offset selects a word
load  in  1  1=load, 0=store
data_from_cpu  in  DATA_WIDTH  store data
data_to_cpu  out  DATA_WIDTH  load data, valid when hit=1
hit  out  1  request completes this cycle (dvalid)
command_valid  out  1  bus command valid
command_store  out  1  1=line write-back, 0=line read
command_rready  out  1  ready to accept read data
command_addr  out  ADDR_WIDTH  line address, offset bits zero
data_to_bus  out  DATA_WIDTH*2**OFFSET_LENGTH  write-back line
data_from_bus  in  DATA_WIDTH*2**OFFSET_LENGTH  fill line
bus_valid  in  1  fill data valid
bus_ready  in  1  write-back accepted
invalidate  in  1  snoop invalidate
invalidate_addr  in  ADDR_WIDTH  snooped address

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all valid, dirty and age bits cleared.
  - All command_* outputs, data_to_bus, hit and data_to_cpu are 0.
  - Data/tag arrays are not reset.
- Per-set storage, per way: valid, dirty, tag, line, WAY_BITS age.
- Word w of a line occupies line bits [w*DATA_WIDTH +: DATA_WIDTH].
- hit (combinational) = state==IDLE && avalid && !invalidate && some way valid with matching tag. data_to_cpu = addressed word of the hitting way, else 0.
- Load hit: zero latency; data returned the same cycle.
- Store hit: at the clock edge, write the word into the hitting way and set dirty=1.
- LRU update, on every hit and every fill:
  - accessed way's age <= 0;
  - ways whose age < old age of the accessed way increment;
  - others unchanged.
  - Ages in a set are always a permutation of 0..WAYS-1 once the set is full.
- Victim selection on miss: lowest-index invalid way; else the way with age==WAYS-1.
- On a miss in IDLE (avalid, !invalidate, no hit), at the clock edge:
  - latch victim way, victim line and victim address {victim_tag,index,0}.
  - Dirty victim: go to WRITEBACK. Otherwise go to FILL.
- WRITEBACK:
  - command_valid=1, command_store=1, command_rready=0, command_addr=latched victim address, data_to_bus=latched line.
  - Held until bus_ready=1, then FILL.
- FILL:
  - command_valid=1, command_store=0, command_rready=1, command_addr={tag,index,0} of the request.
  - On bus_valid, write into the victim way: line=data_from_bus, tag, valid=1, LRU update.
  - Store request: the stored word is merged over the bus word and dirty=1. Load request: dirty=0.
  - Next state IDLE; hit asserts in the following cycle.
- IDLE outputs: command_* = 0, data_to_bus = 0.
- Miss latency: clean victim = bus latency + 1 cycle; dirty victim adds the write-back handshake.
- Invalidate:
  - Any state, any cycle: the way in invalidate_addr's set whose tag matches and is valid gets valid=0 and dirty=0. Data is discarded, no write-back.
  - Ages are unchanged.
  - In IDLE it also blocks that cycle's CPU request (hit=0, no miss started).
  - During WRITEBACK the latched copy is still written back.
  - Invalidate and fill of the same way in the same cycle: fill wins (line valid).
- A request's address must not change while state!=IDLE; behaviour is undefined otherwise.
- reset asserted mid-WRITEBACK or mid-FILL: outputs drop immediately, the transaction is abandoned, all lines become invalid.

Test Plan:
Config for all scenarios: ADDR_WIDTH=16, INDEX_LENGTH=2, OFFSET_LENGTH=2, WAYS=2, DATA_WIDTH=64.
1. After reset, load 0x0010 → next cycle command_valid=1, store=0, rready=1, addr=0x0010; no store command issued. Bus returns words 0xA0..0xA3 with bus_valid → following cycle hit=1, data_to_cpu=0xA0.
2. Store 0x0011 data 0x55 (hit) → hit=1 same cycle; then load 0x0011 → 0x55, hit=1. Load 0x0020 misses → fills way1 with 0xB0..0xB3.
3. Load 0x0030 (set0, both ways valid, way0 LRU and dirty):
   - WRITEBACK with addr=0x0010; data_to_bus word1=0x55, word0=0xA0.
   - Held 3 cycles with bus_ready=0, then bus_ready=1.
   - FILL addr=0x0030 follows; after the fill, load 0x0030 hits.
4. Load 0x0040 (victim way1 tag 0x002, clean) → no store command; goes directly to FILL addr=0x0040.
5. invalidate=1, invalidate_addr=0x0030 with avalid load 0x0030 in the same cycle → hit=0. Next cycle (invalidate=0) misses → FILL 0x0030.
6. reset driven low mid-FILL → command_valid=0 asynchronously. After release, load 0x0040 misses (all lines invalid).
